// File: rtl/md_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: MD op codes and FSM states.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic             we_hilo;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, we_hilo, a, b, input busy, hi, lo);
  modport slave  (input start, md_op, we_hilo, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Fixed-latency MULT/MULTU/DIV/DIVU unit with HI/LO registers and single-cycle MTHI/MTLO.
// The result is computed when the op starts and committed to HI/LO when the busy window ends.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  md_unit_if.slave   md
);

  localparam int unsigned PW      = 2 * WIDTH;
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;

  logic             signed_op;
  logic [PW-1:0]    mul_a, mul_b, prod;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

  // Sign/magnitude divide keeps MIN / -1 well defined (quotient wraps to MIN, remainder 0).
  always_comb begin
    signed_op = (md.md_op == MD_MULT) || (md.md_op == MD_DIV);
    mul_a     = {{WIDTH{signed_op & md.a[WIDTH-1]}}, md.a};
    mul_b     = {{WIDTH{signed_op & md.b[WIDTH-1]}}, md.b};
    prod      = mul_a * mul_b;
    a_neg     = signed_op & md.a[WIDTH-1];
    b_neg     = signed_op & md.b[WIDTH-1];
    a_mag     = a_neg ? (WIDTH'(0) - md.a) : md.a;
    b_mag     = b_neg ? (WIDTH'(0) - md.b) : md.b;
    b_div     = (b_mag == WIDTH'(0)) ? WIDTH'(1) : b_mag;
    q_mag     = a_mag / b_div;
    r_mag     = a_mag % b_div;
    quo       = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
    rem       = a_neg ? (WIDTH'(0) - r_mag) : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;

    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          if (md.md_op == MD_MULT || md.md_op == MD_MULTU) begin
            state_d   = MUL;
            cnt_d     = CNT_W'(MULT_CYCLES - 1);
            pend_hi_d = prod[PW-1:WIDTH];
            pend_lo_d = prod[WIDTH-1:0];
            pend_wr_d = 1'b1;
            busy_d    = 1'b1;
          end else if (md.md_op == MD_DIV || md.md_op == MD_DIVU) begin
            state_d   = DIV;
            cnt_d     = CNT_W'(DIV_CYCLES - 1);
            pend_hi_d = rem;
            pend_lo_d = quo;
            pend_wr_d = (md.b != WIDTH'(0));
            busy_d    = 1'b1;
          end
        end else if (md.we_hilo) begin
          if (md.md_op == MD_MTHI) hi_d = md.a;
          if (md.md_op == MD_MTLO) lo_d = md.a;
        end
      end
      MUL, DIV: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops push expected HI/LO and busy length,
// a negedge monitor pops and compares on each completion.
module tb_md_unit;
  import md_unit_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .md    (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_viol   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input int cyc, input logic [31:0] eh,
                       input logic [31:0] el, input string name);
    exp_t e;
    e.cyc = cyc; e.hi = eh; e.lo = el; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.we_hilo = we; bus.md_op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.we_hilo = 1'b0;
    repeat (cyc + 2) @(posedge clk);
    #1;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a, input logic [31:0] eh,
                    input logic [31:0] el, input string name);
    exp_t e;
    e.cyc = 0; e.hi = eh; e.lo = el; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.we_hilo = 1'b1; bus.md_op = op; bus.a = a; bus.b = 32'h0;
    @(posedge clk); #1;
    bus.we_hilo = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: completions are a busy fall, or the cycle after an accepted MTHI/MTLO.
  initial begin
    int   bcnt;
    logic prev_busy;
    logic mt_pend;
    exp_t e;
    bcnt = 0; prev_busy = 1'b0; mt_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0; prev_busy = 1'b0; mt_pend = 1'b0;
      end else begin
        if (mt_pend) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL mt_unexpected: got completion expected none at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_busy"}, 32'(bus.busy), 32'h0);
            chk({e.name, "_hi"}, bus.hi, e.hi);
            chk({e.name, "_lo"}, bus.lo, e.lo);
          end
        end
        if (bus.busy) begin
          bcnt++;
          if (bus.start || bus.we_hilo) begin
            n_viol++;
            $display("note: request presented while busy at %0t", $time);
          end
        end else if (prev_busy) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL op_unexpected: got completion expected none at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_cycles"}, 32'(bcnt), 32'(e.cyc));
            chk({e.name, "_hi"}, bus.hi, e.hi);
            chk({e.name, "_lo"}, bus.lo, e.lo);
          end
          bcnt = 0;
        end
        prev_busy = bus.busy;
        mt_pend   = bus.we_hilo && !bus.start && !bus.busy;
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.we_hilo = 1'b0; bus.md_op = 3'd0; bus.a = '0; bus.b = '0;
    #12;
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(MD_MULT,  32'hFFFFFFFE, 32'h00000003, 1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg");
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5,  32'hFFFFFFFE, 32'h00000001, "multu_max");
    issue(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7");
    issue(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000, "div_ovf");
    mt(MD_MTHI, 32'h00000011, 32'h00000011, 32'h80000000, "mthi");
    mt(MD_MTLO, 32'h00000022, 32'h00000011, 32'h00000022, "mtlo");
    issue(MD_DIVU,  32'h00000005, 32'h00000000, 1'b0, 10, 32'h00000011, 32'h00000022, "divu_zero");
    issue(MD_DIV,   32'h00000007, 32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD, "div_negb");
    issue(MD_DIVU,  32'h00000064, 32'h00000007, 1'b0, 10, 32'h00000002, 32'h0000000E, "divu_100");
    issue(MD_MULTU, 32'h00000006, 32'h00000007, 1'b1, 5,  32'h00000000, 32'h0000002A, "start_we");

    // Asynchronous reset in busy cycle 3 of a MULT discards the result.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.md_op = MD_MULT; bus.a = 32'h00001234; bus.b = 32'h00005678;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    chk("rst_mid_hi", bus.hi, 32'h0);
    chk("rst_mid_lo", bus.lo, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(MD_MULT, 32'h00000005, 32'hFFFFFFFC, 1'b0, 5, 32'hFFFFFFFF, 32'hFFFFFFEC, "post_rst");

    // A second start in busy cycle 2 must be ignored.
    begin
      exp_t e;
      e.cyc = 5; e.hi = 32'h00000001; e.lo = 32'h00000000; e.name = "ign_start";
      sb.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.md_op = MD_MULTU; bus.a = 32'h00010000; bus.b = 32'h00010000;
      @(posedge clk); #1 bus.start = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.md_op = MD_MULTU; bus.a = 32'h00000003; bus.b = 32'h00000003;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
    end
    chk("busy_violation_count", 32'(n_viol), 32'h1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
